ms_timer_sched: RTL and testbench
=================================

// Module: ms_timer_sched
// PURPOSE
//  Multi-channel millisecond timeout scheduler driven by the shared 1 ms tick pulse.
//  Each requester arms its channel with a duration in ms; the block counts the channels down.
//  Expiries are reported one at a time on a valid/ready event port, with round-robin
//  arbitration between channels that expire together.
//  Sits between the 1 ms tick generator and the control FSMs that need timeouts.
// PARAMETERS
//  NCH  4   number of timer channels (2..16)
//  CW   16  duration/counter width in ms
//  IDW  2   event id width, equal to clog2(NCH)
// PORTS
//  clk        in   1       system clock
//  rst        in   1       synchronous reset, active-high
//  tick_1ms   in   1       one-clk pulse every 1 ms from the tick generator
//  start      in   NCH     per-channel arm/re-arm strobe (one clk)
//  cancel     in   NCH     per-channel disarm strobe (one clk)
//  dur        in   NCH*CW  per-channel duration; channel i uses dur[i*CW +: CW]; sampled on start
//  busy       out  NCH     channel is RUN or PEND
//  evt_valid  out  1       expiry event available
//  evt_id     out  IDW     channel number of the presented event
//  evt_ready  in   1       consumer accepts the event when evt_valid && evt_ready
//  periodic   in   NCH     auto-reload select, sampled on start (only with TMR_PERIODIC_EN)
//  overrun    out  NCH     sticky: periodic channel expired again before its event was accepted
// BEHAVIOUR
//  Per-channel state: IDLE, RUN, PEND. Per-channel registers: rem[CW], rld[CW].
//  Reset: all channels IDLE, rem=0, busy=0, evt_valid=0, evt_id=0, overrun=0, RR pointer=0.
//  start (IDLE/RUN/PEND):
//   - rem<=dur and rld<=dur on the next edge; state -> RUN; a pending, unpresented event is dropped.
//   - dur==0 -> state -> PEND directly (expires without waiting for a tick).
//  cancel: state -> IDLE next edge. cancel together with start: cancel wins.
//  Tick in RUN:
//   - rem>1 -> rem<=rem-1.
//   - rem==1 -> rem<=0, state -> PEND.
//   - A start on the same cycle as a tick loads dur and ignores that tick.
//  Arbiter:
//   - Runs when evt_valid==0 or on an accepting handshake.
//   - Picks the first PEND channel at or after the RR pointer, with wrap-around.
//   - Registers the pick: evt_valid<=1, evt_id<=ch. The pick is visible one clk after PEND.
//   - Pointer <= ch+1 mod NCH.
//  Presented event:
//   - evt_valid and evt_id hold stable until accepted. Never withdrawn, even if that channel
//     is cancelled or re-armed meanwhile.
//   - On accept, the channel goes PEND->IDLE, unless it was re-armed/cancelled after
//     presentation; in that case its new state is kept.
//  Handshake throughput: back-to-back accepts give one event per clk when several channels are PEND.
//  Tick arriving while a channel is PEND: ignored for that channel (non-periodic).
//  Latency: tick with rem==1 -> evt_valid at tick+2 clk when the port is free.
//  Mid-operation reset: all state cleared in one edge; any presented event is lost.
// CONFIGURATION
//  TMR_PERIODIC_EN defined:
//   - periodic[] and overrun[] ports exist.
//   - A periodic channel reaching expiry sets PEND and reloads rem<=rld in the same edge.
//     It keeps counting while PEND.
//   - Expiring again while still PEND sets overrun[i]; that second event is not queued.
//   - Accepting its event clears PEND and leaves the channel counting; state is RUN, busy stays 1.
//   - overrun[i] is cleared by start[i] or cancel[i].
//   - rld==0 with periodic -> treated as non-periodic.
//  TMR_PERIODIC_EN undefined: ports absent; all channels one-shot; no overrun logic.
// TESTING
//  1. start[0], dur=3, evt_ready=1 -> evt_valid rises 2 clk after the 3rd tick, id=0; busy[0]=0 next clk.
//  2. ch1 and ch2 armed with dur=5 together, ready=1 -> events id=1 then id=2 on consecutive clks;
//     the next collision starts from ch3 and wraps.
//  3. start[2] with dur=0 -> evt_valid, id=2 within 2 clk, no tick needed.
//  4. evt_ready=0 for 10 clk while ch3 PEND; cancel[3] meanwhile -> id=3 stays stable;
//     after accept ch3 is IDLE, no second event.
//  5. start and cancel on ch0 in the same clk -> ch0 IDLE; rst mid-count (rem=7) -> all outputs 0 next clk.
//  6. (TMR_PERIODIC_EN) ch1 periodic dur=2, ready=0 -> 1st event held, overrun[1]=1 at the 4th tick;
//     ready=1 -> one event; events every 2 ticks after that.

Source files
------------

// File: rtl/ms_timer_sched.sv
// ms_timer_sched: multi-channel 1 ms timeout scheduler with round-robin expiry event port.
// Optional auto-reload channels and overrun flags are built when TMR_PERIODIC_EN is defined.
`default_nettype none

module ms_timer_sched #(
  parameter int NCH = 4,
  parameter int CW  = 16,
  parameter int IDW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1ms,
  input  logic [NCH-1:0]    start,
  input  logic [NCH-1:0]    cancel,
  input  logic [NCH*CW-1:0] dur,
  output logic [NCH-1:0]    busy,
  output logic              evt_valid,
  output logic [IDW-1:0]    evt_id,
  input  logic              evt_ready
`ifdef TMR_PERIODIC_EN
  ,
  input  logic [NCH-1:0]    periodic,
  output logic [NCH-1:0]    overrun
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  logic           accept;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] clr;
  logic [NCH-1:0] touch;
  logic [IDW-1:0] ptr;
  logic           pres_live;

  assign accept = evt_valid && evt_ready;
  assign touch  = start | cancel;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [1:0]    state;
    logic [CW-1:0] rem;
    logic [CW-1:0] d;
    logic          per_eff;
    logic          counting;
    logic          expire;

    assign d = dur[i*CW +: CW];
`ifdef TMR_PERIODIC_EN
    logic          per_q;
    logic [CW-1:0] rld;
    logic          ovr;
    assign per_eff    = per_q && (rld != '0);
    assign overrun[i] = ovr;
`else
    assign per_eff = 1'b0;
`endif
    // Periodic channels keep counting while their event waits to be accepted.
    assign counting = (state == ST_RUN) || ((state == ST_PEND) && per_eff);
    assign expire   = tick_1ms && counting && (rem == CW'(1));
    // Clear only the event that is still the one on the port.
    assign clr[i]   = accept && pres_live && (evt_id == IDW'(i));
    assign pend[i]  = (state == ST_PEND);
    assign busy[i]  = (state != ST_IDLE);

    always_ff @(posedge clk) begin
      if (rst) begin
        state <= ST_IDLE;
        rem   <= '0;
`ifdef TMR_PERIODIC_EN
        per_q <= 1'b0;
        rld   <= '0;
        ovr   <= 1'b0;
`endif
      end else if (cancel[i]) begin
        state <= ST_IDLE;
`ifdef TMR_PERIODIC_EN
        ovr   <= 1'b0;
`endif
      end else if (start[i]) begin
        rem   <= d;
        state <= (d == '0) ? ST_PEND : ST_RUN;
`ifdef TMR_PERIODIC_EN
        rld   <= d;
        per_q <= periodic[i];
        ovr   <= 1'b0;
`endif
      end else begin
        if (tick_1ms && counting) begin
          if (rem > CW'(1)) begin
            rem <= rem - CW'(1);
          end else begin
`ifdef TMR_PERIODIC_EN
            rem <= per_eff ? rld : '0;
`else
            rem <= '0;
`endif
          end
        end
        if (expire) begin
          state <= ST_PEND;
`ifdef TMR_PERIODIC_EN
          if ((state == ST_PEND) && !clr[i]) ovr <= 1'b1;
`endif
        end else if (clr[i]) begin
          state <= per_eff ? ST_RUN : ST_IDLE;
        end
      end
    end
  end

  logic [NCH-1:0] cand;
  logic           found;
  logic [IDW-1:0] pick;
  logic [IDW-1:0] ptr_nxt;
  int             idx;

  assign cand = pend & ~clr;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  assign ptr_nxt = (int'(pick) == NCH - 1) ? '0 : IDW'(pick + 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      ptr       <= '0;
      pres_live <= 1'b0;
    end else if (!evt_valid || accept) begin
      if (found) begin
        evt_valid <= 1'b1;
        evt_id    <= pick;
        ptr       <= ptr_nxt;
        pres_live <= !touch[pick];
      end else begin
        evt_valid <= 1'b0;
        pres_live <= 1'b0;
      end
    end else if (touch[evt_id]) begin
      pres_live <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ms_timer_sched.sv
// Directed bench for ms_timer_sched with hand-computed expectations.
`default_nettype none

module tb_ms_timer_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_1ms = 1'b0;
  logic [3:0]  start = '0;
  logic [3:0]  cancel = '0;
  logic [63:0] dur = '0;
  logic [3:0]  busy;
  logic        evt_valid;
  logic [1:0]  evt_id;
  logic        evt_ready = 1'b0;
`ifdef TMR_PERIODIC_EN
  logic [3:0]  periodic = '0;
  logic [3:0]  overrun;
`endif

  int nvec = 0;
  int nerr = 0;

  ms_timer_sched #(.NCH(4), .CW(16), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1ms  (tick_1ms),
    .start     (start),
    .cancel    (cancel),
    .dur       (dur),
    .busy      (busy),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_ready (evt_ready)
`ifdef TMR_PERIODIC_EN
    ,
    .periodic  (periodic),
    .overrun   (overrun)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_1ms = 1'b1;
    step();
    tick_1ms = 1'b0;
  endtask

  task automatic set_dur(input int ch, input logic [15:0] d);
    dur[ch*16 +: 16] = d;
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_id", 32'(evt_id), 0);

    // 1: single one-shot, dur=3
    evt_ready = 1'b1;
    set_dur(0, 16'd3);
    start = 4'b0001;
    step();
    start = '0;
    chk("t1_busy_run", 32'(busy), 32'h1);
    tick();
    tick();
    chk("t1_no_evt_early", 32'(evt_valid), 0);
    tick();
    chk("t1_pend_not_yet", 32'(evt_valid), 0);
    step();
    chk("t1_valid", 32'(evt_valid), 1);
    chk("t1_id", 32'(evt_id), 0);
    step();
    chk("t1_valid_drop", 32'(evt_valid), 0);
    chk("t1_busy_idle", 32'(busy), 0);

    // 2: collision ch1/ch2, then wrap from ch3 to ch0/ch1
    set_dur(1, 16'd5);
    set_dur(2, 16'd5);
    start = 4'b0110;
    step();
    start = '0;
    for (int k = 0; k < 5; k++) tick();
    step();
    chk("t2_v1", 32'(evt_valid), 1);
    chk("t2_id1", 32'(evt_id), 1);
    step();
    chk("t2_v2", 32'(evt_valid), 1);
    chk("t2_id2", 32'(evt_id), 2);
    step();
    chk("t2_v_end", 32'(evt_valid), 0);
    set_dur(0, 16'd1);
    set_dur(1, 16'd1);
    start = 4'b0011;
    step();
    start = '0;
    tick();
    step();
    chk("t2_wrap_id0", 32'(evt_id), 0);
    chk("t2_wrap_v0", 32'(evt_valid), 1);
    step();
    chk("t2_wrap_id1", 32'(evt_id), 1);
    step();
    chk("t2_wrap_end", 32'(evt_valid), 0);

    // 3: dur=0 expires without a tick
    set_dur(2, 16'd0);
    start = 4'b0100;
    step();
    start = '0;
    chk("t3_busy_pend", 32'(busy), 32'h4);
    step();
    chk("t3_valid", 32'(evt_valid), 1);
    chk("t3_id", 32'(evt_id), 2);
    step();
    chk("t3_done", 32'(busy), 0);

    // 4: held event survives cancel; no second event
    evt_ready = 1'b0;
    set_dur(3, 16'd0);
    start = 4'b1000;
    step();
    start = '0;
    step();
    for (int k = 0; k < 10; k++) begin
      chk("t4_hold_valid", 32'(evt_valid), 1);
      chk("t4_hold_id", 32'(evt_id), 3);
      if (k == 3) cancel = 4'b1000;
      step();
      cancel = '0;
    end
    chk("t4_cancel_busy", 32'(busy), 0);
    evt_ready = 1'b1;
    step();
    chk("t4_accepted", 32'(evt_valid), 0);
    step();
    step();
    chk("t4_no_second", 32'(evt_valid), 0);
    chk("t4_busy", 32'(busy), 0);

    // 5: cancel wins over start; mid-operation reset
    evt_ready = 1'b0;
    set_dur(0, 16'd5);
    start = 4'b0001;
    cancel = 4'b0001;
    step();
    start = '0;
    cancel = '0;
    chk("t5_cancel_wins", 32'(busy), 0);
    set_dur(0, 16'd0);
    set_dur(1, 16'd10);
    start = 4'b0011;
    step();
    start = '0;
    for (int k = 0; k < 3; k++) tick();
    chk("t5_pre_valid", 32'(evt_valid), 1);
    chk("t5_pre_busy", 32'(busy), 32'h3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_valid", 32'(evt_valid), 0);
    chk("t5_rst_id", 32'(evt_id), 0);
    evt_ready = 1'b1;
    set_dur(3, 16'd0);
    start = 4'b1001;
    step();
    start = '0;
    step();
    chk("t5_ptr_reset_id", 32'(evt_id), 0);
    step();
    chk("t5_second_id", 32'(evt_id), 3);
    step();
    chk("t5_end", 32'(evt_valid), 0);

`ifdef TMR_PERIODIC_EN
    // 6: periodic ch1, dur=2, overrun while held
    evt_ready = 1'b0;
    set_dur(1, 16'd2);
    periodic = 4'b0010;
    start = 4'b0010;
    step();
    start = '0;
    periodic = '0;
    tick();
    tick();
    step();
    chk("t6_first_valid", 32'(evt_valid), 1);
    chk("t6_first_id", 32'(evt_id), 1);
    tick();
    chk("t6_no_ovr_yet", 32'(overrun), 0);
    tick();
    chk("t6_overrun", 32'(overrun), 32'h2);
    chk("t6_held_id", 32'(evt_id), 1);
    evt_ready = 1'b1;
    step();
    chk("t6_one_event", 32'(evt_valid), 0);
    chk("t6_still_busy", 32'(busy), 32'h2);
    for (int r = 0; r < 2; r++) begin
      tick();
      chk("t6_gap", 32'(evt_valid), 0);
      tick();
      step();
      chk("t6_per_valid", 32'(evt_valid), 1);
      chk("t6_per_id", 32'(evt_id), 1);
      step();
      chk("t6_per_end", 32'(evt_valid), 0);
    end
    cancel = 4'b0010;
    step();
    cancel = '0;
    chk("t6_ovr_clear", 32'(overrun), 0);
    chk("t6_idle", 32'(busy), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
